mult_secuencial: RTL

MULT_SECUENCIAL -- requirements
Module: mult_secuencial

---
 rtl/mult_secuencial_pkg.sv | 21 ++
 rtl/mult_paso.sv | 41 ++++
 rtl/mult_secuencial.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mult_secuencial_pkg.sv
// rtl/mult_secuencial_pkg.sv - shared defaults, FSM encoding and sign helper
// Shared with the downstream truncation/saturation stage.
package mult_secuencial_pkg;

  localparam int N_DEF  = 25;
  localparam int FA_DEF = 14;
  localparam int FB_DEF = 19;
  localparam int SIGN_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

  function automatic logic [SIGN_W-1:0] result_sign(input logic a_msb, input logic b_msb);
    return a_msb ^ b_msb;
  endfunction

endpackage

// File: rtl/mult_paso.sv
// rtl/mult_paso.sv - one combinational shift-add step on unsigned magnitudes
// MULT_RADIX4_EN selects 2 multiplier bits per step instead of 1.
module mult_paso #(
  parameter int N = 25
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] a_sh,
  input  logic [N-1:0]   b_sh,
  output logic [2*N-1:0] acc_next,
  output logic [2*N-1:0] a_sh_next,
  output logic [N-1:0]   b_sh_next
);

  logic [2*N-1:0] pp;

`ifdef MULT_RADIX4_EN
  always_comb begin
    pp = '0;
    case (b_sh[1:0])
      2'd0: pp = '0;
      2'd1: pp = a_sh;
      2'd2: pp = a_sh << 1;
      2'd3: pp = a_sh + (a_sh << 1);
      default: pp = '0;
    endcase
  end
  assign a_sh_next = a_sh << 2;
  assign b_sh_next = b_sh >> 2;
`else
  always_comb begin
    pp = '0;
    if (b_sh[0]) pp = a_sh;
  end
  assign a_sh_next = a_sh << 1;
  assign b_sh_next = b_sh >> 1;
`endif

  // Multiplicand shifts left instead of the accumulator shifting right, so no bits are ever dropped.
  assign acc_next = acc + pp;

endmodule

// File: rtl/mult_secuencial.sv
// rtl/mult_secuencial.sv - iterative signed fixed-point multiplier, full-width product
// MULT_RADIX4_EN halves the number of MULT cycles; results are identical.
module mult_secuencial
  import mult_secuencial_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int FA = FA_DEF,
  parameter int FB = FB_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   Dato_A,
  input  logic [N-1:0]   Dato_B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Datos_Sum,
  output logic           busy
);

`ifdef MULT_RADIX4_EN
  localparam int STEPS = (N + 1) / 2;
`else
  localparam int STEPS = N;
`endif
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (FA + FB > 2*N - 2) begin : g_frac_check
    $error("mult_secuencial: FA+FB exceeds product fraction range");
  end

  mult_state_t      state_q, state_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [2*N-1:0]   sum_q, sum_d;
  logic             valid_q, valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [2*N-1:0]   acc_step, a_step;
  logic [N-1:0]     b_step;

  // Exact for -2^(N-1): the N-bit unsigned result is 2^(N-1).
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  mult_paso #(.N(N)) u_paso (
    .acc       (acc_q),
    .a_sh      (a_q),
    .b_sh      (b_q),
    .acc_next  (acc_step),
    .a_sh_next (a_step),
    .b_sh_next (b_step)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    step_d  = step_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MULT;
          acc_d   = '0;
          a_d     = {{N{1'b0}}, magnitude(Dato_A)};
          b_d     = magnitude(Dato_B);
          sign_d  = result_sign(Dato_A[N-1], Dato_B[N-1]);
          step_d  = '0;
        end
      end
      ST_MULT: begin
        acc_d  = acc_step;
        a_d    = a_step;
        b_d    = b_step;
        step_d = step_q + CNT_W'(1);
        if (step_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (sign_q && (acc_q != '0)) acc_d = '0 - acc_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle loads the output register; the product is then held until taken.
        if (!valid_q) begin
          valid_d = 1'b1;
          sum_d   = acc_q;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      step_q     <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      step_q     <= step_d;
      sum_q      <= sum_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = valid_q;
  assign Datos_Sum = sum_q;
  assign busy      = busy_q;

endmodule
